led_pwm_bank: RTL and testbench

LED_PWM_BANK -- requirements
Module: led_pwm_bank

---
 rtl/led_pwm_bank.sv | 145 ++++++++++++++
 tb/tb_led_pwm_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/led_pwm_bank.sv
// LED PWM bank: N_CH channels, each off / on / PWM / blink, driven by a
// shared free-running PWM counter and a shared blink prescaler. Config is
// written and read through a single-cycle strobe bus.

// Per-channel slice: owns its config register and its registered LED bit.
module led_pwm_lane #(
  parameter int PWM_W = 8
) (
  input  logic             clk50_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [PWM_W+1:0] wdata_i,
  input  logic [PWM_W-1:0] pcnt_i,
  input  logic             phase_i,
  output logic [PWM_W+1:0] cfg_o,
  output logic             led_o
);
  logic [PWM_W+1:0] cfg_q;
  logic             led_q, led_d;

  // Mode decode from the currently held config.
  always_comb begin
    led_d = 1'b0;
    case (cfg_q[PWM_W+1:PWM_W])
      2'b00:   led_d = 1'b0;
      2'b01:   led_d = 1'b1;
      2'b10:   led_d = (pcnt_i < cfg_q[PWM_W-1:0]);
      default: led_d = phase_i;
    endcase
  end

  // Config load and LED register; a new config shows on LEDs one edge later.
  always_ff @(posedge clk50_i) begin
    if (!rst_n_i) begin
      cfg_q <= '0;
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
      if (we_i) cfg_q <= wdata_i;
    end
  end

  assign cfg_o = cfg_q;
  assign led_o = led_q;
endmodule

module led_pwm_bank #(
  parameter int N_CH      = 8,
  parameter int PWM_W     = 8,
  parameter int BLINK_DIV = 25000000,
  parameter int ADDR_W    = 3
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PWM_W+1:0]  wdata,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [PWM_W+1:0]  rd_data,
  output logic              rd_valid,
  output logic [N_CH-1:0]   LEDS
);
  localparam int BCNT_W = $clog2(BLINK_DIV);

  logic [PWM_W-1:0]             pcnt_q, pcnt_d;
  logic [BCNT_W-1:0]            bcnt_q, bcnt_d;
  logic                         phase_q, phase_d;
  logic [N_CH-1:0][PWM_W+1:0]   cfg_w;
  logic [N_CH-1:0]              lane_we;
  logic [PWM_W+1:0]             rd_mux;
  logic                         addr_ok;
  logic                         wr_ack_q, wr_err_q, rd_valid_q;
  logic [PWM_W+1:0]             rd_data_q;

  // Compare at full int width so N_CH == 2^ADDR_W never aliases to zero.
  assign addr_ok = (32'(addr) < N_CH);

  // Shared timebase: PWM counter wraps naturally, prescaler flips phase.
  always_comb begin
    pcnt_d  = pcnt_q + 1'b1;
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Timebase registers; config traffic never touches them.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Read mux by equality compare, so an out-of-range address selects nothing.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++)
      if (addr == ADDR_W'(i)) rd_mux = cfg_w[i];
  end

  // Bus responses: one-cycle pulses, rd_data held between reads.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ack_q   <= wr_en & addr_ok;
      wr_err_q   <= (wr_en | rd_en) & ~addr_ok;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    assign lane_we[g] = wr_en & (addr == ADDR_W'(g));

    led_pwm_lane #(.PWM_W(PWM_W)) u_lane (
      .clk50_i (clk50),
      .rst_n_i (rst_n),
      .we_i    (lane_we[g]),
      .wdata_i (wdata),
      .pcnt_i  (pcnt_q),
      .phase_i (phase_q),
      .cfg_o   (cfg_w[g]),
      .led_o   (LEDS[g])
    );
  end

  assign wr_ack   = wr_ack_q;
  assign wr_err   = wr_err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank (N_CH=8, PWM_W=8, BLINK_DIV=4, ADDR_W=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_led_pwm_bank;
  logic       clk50 = 1'b0;
  logic       rst_n, wr_en, rd_en;
  logic [3:0] addr;
  logic [9:0] wdata;
  logic       wr_ack, wr_err, rd_valid;
  logic [9:0] rd_data;
  logic [7:0] LEDS;

  int n_checks = 0;
  int n_err    = 0;

  led_pwm_bank #(.N_CH(8), .PWM_W(8), .BLINK_DIV(4), .ADDR_W(4)) dut (
    .clk50(clk50), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .LEDS(LEDS)
  );

  always #5 clk50 = ~clk50;

  task automatic tick();
    @(negedge clk50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt, trans, bad, mism, last_t;
    logic prev;

    // Reset held 3 cycles with a write strobe that must be discarded.
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0; addr = 4'd0; wdata = 10'h3FF;
    repeat (3) begin
      tick();
      chk("rst_leds", LEDS, 8'h00);
      chk("rst_ack", wr_ack, 1'b0);
    end
    chk("rst_rdv", rd_valid, 1'b0);

    // Release and read ch0: must be cleared.
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 4'd0;
    tick();
    chk("rd0_valid", rd_valid, 1'b1);
    chk("rd0_data", rd_data, 10'h000);
    chk("rd0_noack", wr_ack, 1'b0);

    // Write ch7 = on, with a same-cycle read returning the old value.
    wr_en = 1'b1; rd_en = 1'b1; addr = 4'd7; wdata = 10'h100;
    tick();
    chk("w7_ack", wr_ack, 1'b1);
    chk("w7_rdv", rd_valid, 1'b1);
    chk("w7_rdold", rd_data, 10'h000);
    chk("w7_led_pre", LEDS[7], 1'b0);
    wr_en = 1'b0;
    tick();
    chk("w7_ack_off", wr_ack, 1'b0);
    chk("w7_led_on", LEDS[7], 1'b1);
    chk("w7_rdnew", rd_data, 10'h100);
    chk("w7_rdv_b2b", rd_valid, 1'b1);
    rd_en = 1'b0;
    tick();
    chk("rdv_off", rd_valid, 1'b0);
    chk("rd_hold", rd_data, 10'h100);

    // Out-of-range write then read.
    wr_en = 1'b1; addr = 4'd8; wdata = 10'h3FF;
    tick();
    chk("bad_wr_err", wr_err, 1'b1);
    chk("bad_wr_ack", wr_ack, 1'b0);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    chk("bad_rd_err", wr_err, 1'b1);
    chk("bad_rd_valid", rd_valid, 1'b1);
    chk("bad_rd_data", rd_data, 10'h000);
    addr = 4'd0;
    tick();
    chk("bad_cfg0", rd_data, 10'h000);
    chk("bad_err_off", wr_err, 1'b0);
    chk("bad_leds", LEDS, 8'h80);
    rd_en = 1'b0;

    // PWM ch2, three duties, 256 consecutive samples each.
    wr_en = 1'b1; addr = 4'd2; wdata = 10'h240;
    tick(); wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin tick(); cnt += int'(LEDS[2]); end
    chk("pwm_40", cnt, 64);
    wr_en = 1'b1; wdata = 10'h200;
    tick(); wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin tick(); cnt += int'(LEDS[2]); end
    chk("pwm_00", cnt, 0);
    wr_en = 1'b1; wdata = 10'h2FF;
    tick(); wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin tick(); cnt += int'(LEDS[2]); end
    chk("pwm_ff", cnt, 255);

    // Blink ch5 and ch6 with different duty fields.
    wr_en = 1'b1; addr = 4'd5; wdata = 10'h3AB;
    tick();
    addr = 4'd6; wdata = 10'h300;
    tick(); wr_en = 1'b0;
    trans = 0; bad = 0; mism = 0; last_t = -1; prev = LEDS[5];
    for (int i = 0; i < 40; i++) begin
      tick();
      if (LEDS[5] !== LEDS[6]) mism++;
      if (LEDS[5] !== prev) begin
        if (last_t >= 0 && i - last_t != 4) bad++;
        last_t = i;
        trans++;
      end
      prev = LEDS[5];
    end
    chk("blink_lockstep", mism, 0);
    chk("blink_halfper", bad, 0);
    chk("blink_toggles", 32'(trans >= 9), 1);

    // Reset mid-PWM, then check cfg cleared and pcnt restarted at 0.
    wr_en = 1'b1; addr = 4'd2; wdata = 10'h240;
    tick(); wr_en = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_leds", LEDS, 8'h00);
    rst_n = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 4'd2; wdata = 10'h210;
    tick();
    chk("mid_rd_cleared", rd_data, 10'h000);
    chk("mid_rd_valid", rd_valid, 1'b1);
    chk("mid_wr_ack", wr_ack, 1'b1);
    chk("mid_led_s1", LEDS[2], 1'b0);
    wr_en = 1'b0; rd_en = 1'b0;
    // pcnt after release edge is 1, so samples 2..16 see pcnt 1..15 < 16.
    for (int i = 2; i <= 20; i++) begin
      tick();
      chk("mid_pcnt_restart", LEDS[2], (i <= 16) ? 1'b1 : 1'b0);
    end
    chk("mid_other_leds", LEDS & 8'hFB, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
